// File: rtl/multicycle_controller_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_controller_pkg
// Shared definitions for the multicycle RV32I-subset control unit: FSM state
// encoding, opcode constants, datapath select codes (ALU operand A/B, result
// source, immediate format), ALU function codes and the branch-condition helper.
// -----------------------------------------------------------------------------
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_BRANCH,
    S_LINK,
    S_JUMP,
    S_LUI,
    S_ILLEGAL
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // func7 values accepted for R-type: base encoding and the SUB alternate.
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_func_t;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_t;

  typedef enum logic [1:0] {
    A_PC    = 2'b00,
    A_OLDPC = 2'b01,
    A_REG   = 2'b10,
    A_ZERO  = 2'b11
  } asel_t;

  typedef enum logic [1:0] {
    B_REG  = 2'b00,
    B_IMM  = 2'b01,
    B_FOUR = 2'b10
  } bsel_t;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_ALURESULT = 2'b01,
    RES_MDR       = 2'b10,
    RES_PC        = 2'b11
  } result_src_t;

  typedef struct packed {
    logic legal;
    logic taken;
  } branch_t;

  // Branch condition from the SUB result flags: eq/ne use zero, lt/ge use sign.
  function automatic branch_t branch_eval(input logic [2:0] func3,
                                          input logic       zero,
                                          input logic       sign);
    branch_t r;
    r.legal = 1'b1;
    r.taken = 1'b0;
    case (func3)
      3'b000:  r.taken = zero;
      3'b001:  r.taken = ~zero;
      3'b100:  r.taken = sign;
      3'b101:  r.taken = ~sign;
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// -----------------------------------------------------------------------------
// multicycle_controller_if
// Controller <-> datapath bundle.
//   datapath -> controller : opcode, func3, func7 (instruction fields),
//                            zero, sign (ALU result flags)
//   controller -> datapath : PCwrite, AdrSel, MemWrite, OldPCwrite, IRwrite,
//                            RegWrite, ALUsrcAsel, ALUsrcBsel, ResultSrc,
//                            ImmSrc, ALUfunc
// master = controller side, slave = datapath side.
// -----------------------------------------------------------------------------
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       zero;
  logic       sign;

  logic       PCwrite;
  logic       AdrSel;
  logic       MemWrite;
  logic       OldPCwrite;
  logic       IRwrite;
  logic       RegWrite;
  logic [1:0] ALUsrcAsel;
  logic [1:0] ALUsrcBsel;
  logic [1:0] ResultSrc;
  logic [2:0] ImmSrc;
  logic [2:0] ALUfunc;

  modport master (
    input  opcode, func3, func7, zero, sign,
    output PCwrite, AdrSel, MemWrite, OldPCwrite, IRwrite, RegWrite,
           ALUsrcAsel, ALUsrcBsel, ResultSrc, ImmSrc, ALUfunc
  );

  modport slave (
    output opcode, func3, func7, zero, sign,
    input  PCwrite, AdrSel, MemWrite, OldPCwrite, IRwrite, RegWrite,
           ALUsrcAsel, ALUsrcBsel, ResultSrc, ImmSrc, ALUfunc
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// -----------------------------------------------------------------------------
// multicycle_controller_alu_decoder
// Combinational ALU function decode for R-type and I-type ALU instructions.
//   func3, func7 : instruction fields
//   is_rtype     : 1 = R-type (func7 checked), 0 = I-type (func7 ignored)
//   alu_func     : ALU operation; ADD whenever the encoding is not legal
//   legal        : encoding is supported
// -----------------------------------------------------------------------------
module multicycle_controller_alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       is_rtype,
  output alu_func_t  alu_func,
  output logic       legal
);

  always_comb begin
    // NOTE: every combinational output is defaulted first so no path through
    // the case statements can leave it unassigned and infer a latch.
    alu_func = ALU_ADD;
    legal    = 1'b1;
    case (func3)
      3'b000:  alu_func = (is_rtype && func7 == F7_ALT) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_func = ALU_AND;
      3'b110:  alu_func = ALU_OR;
      3'b100:  alu_func = ALU_XOR;
      3'b010:  alu_func = ALU_SLT;
      default: legal    = 1'b0;
    endcase
    // R-type needs func7 all-zero; only ADD/SUB accepts the alternate form.
    if (is_rtype && func7 != F7_BASE && !(func3 == 3'b000 && func7 == F7_ALT))
      legal = 1'b0;
    // Keep the ALU on a harmless operation while the FSM heads to ILLEGAL.
    if (!legal)
      alu_func = ALU_ADD;
  end

endmodule

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Moore control FSM for the multicycle RV32I-subset core, one state per cycle.
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset
//   bus     : controller side of multicycle_controller_if (instruction fields
//             and ALU flags in, datapath selects and write enables out)
//   illegal : sticky illegal-instruction flag, cleared only by reset
//   instret : retired-instruction count, wraps modulo 2**CNT_W
// Outputs decode from the current state; PCwrite in BRANCH also depends on
// zero/sign, and ALUfunc in EXEC_R/EXEC_I comes from the ALU decoder.
// -----------------------------------------------------------------------------
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_controller_if.master bus,
  output logic                    illegal,
  output logic [CNT_W-1:0]        instret
);

  state_t    state;
  alu_func_t dec_func;
  logic      dec_legal;
  logic      is_rtype;
  branch_t   br;
  logic      pc_write, mem_write, oldpc_write, ir_write, reg_write;

  assign is_rtype = (state == S_EXEC_R);
  assign br       = branch_eval(bus.func3, bus.zero, bus.sign);

  multicycle_controller_alu_decoder u_alu_decoder (
    .func3    (bus.func3),
    .func7    (bus.func7),
    .is_rtype (is_rtype),
    .alu_func (dec_func),
    .legal    (dec_legal)
  );

  // NOTE: state, flag and counter are registers, so they use non-blocking
  // assignments; every update sees the values from before the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_FETCH;
      illegal <= 1'b0;
      instret <= '0;
    end else begin
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          case (bus.opcode)
            OP_LOAD, OP_STORE: state <= S_MEMADR;
            OP_RTYPE:          state <= S_EXEC_R;
            OP_ITYPE:          state <= S_EXEC_I;
            OP_BRANCH:         state <= S_BRANCH;
            OP_JAL, OP_JALR:   state <= S_LINK;
            OP_LUI:            state <= S_LUI;
            default: begin
              state   <= S_ILLEGAL;
              illegal <= 1'b1;
            end
          endcase
        end
        S_MEMADR:  state <= (bus.opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD: state <= S_MEMWB;
        S_EXEC_R, S_EXEC_I: begin
          if (dec_legal) begin
            state <= S_ALUWB;
          end else begin
            state   <= S_ILLEGAL;
            illegal <= 1'b1;
          end
        end
        S_BRANCH: begin
          if (br.legal) begin
            state   <= S_FETCH;
            instret <= instret + CNT_W'(1);
          end else begin
            state   <= S_ILLEGAL;
            illegal <= 1'b1;
          end
        end
        S_LINK: state <= S_JUMP;
        // Final cycle of every other instruction: retire.
        S_MEMWB, S_MEMWRITE, S_ALUWB, S_JUMP, S_LUI: begin
          state   <= S_FETCH;
          instret <= instret + CNT_W'(1);
        end
        S_ILLEGAL: state <= S_ILLEGAL;
        default:   state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_write       = 1'b0;
    mem_write      = 1'b0;
    oldpc_write    = 1'b0;
    ir_write       = 1'b0;
    reg_write      = 1'b0;
    bus.AdrSel     = 1'b0;
    bus.ALUsrcAsel = A_PC;
    bus.ALUsrcBsel = B_REG;
    bus.ResultSrc  = RES_ALUOUT;
    bus.ImmSrc     = IMM_I;
    bus.ALUfunc    = ALU_ADD;
    case (state)
      S_FETCH: begin
        ir_write       = 1'b1;
        oldpc_write    = 1'b1;
        pc_write       = 1'b1;
        bus.ALUsrcBsel = B_FOUR;
        bus.ResultSrc  = RES_ALURESULT;
      end
      S_DECODE: begin
        // Branch target is precomputed here and parked in ALUout.
        bus.ALUsrcAsel = A_OLDPC;
        bus.ALUsrcBsel = B_IMM;
        bus.ImmSrc     = IMM_B;
      end
      S_MEMADR: begin
        bus.ALUsrcAsel = A_REG;
        bus.ALUsrcBsel = B_IMM;
        bus.ImmSrc     = (bus.opcode == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD:  bus.AdrSel = 1'b1;
      S_MEMWB: begin
        bus.ResultSrc = RES_MDR;
        reg_write     = 1'b1;
      end
      S_MEMWRITE: begin
        bus.AdrSel = 1'b1;
        mem_write  = 1'b1;
      end
      S_EXEC_R: begin
        bus.ALUsrcAsel = A_REG;
        bus.ALUfunc    = dec_func;
      end
      S_EXEC_I: begin
        bus.ALUsrcAsel = A_REG;
        bus.ALUsrcBsel = B_IMM;
        bus.ALUfunc    = dec_func;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_BRANCH: begin
        bus.ALUsrcAsel = A_REG;
        bus.ALUfunc    = ALU_SUB;
        pc_write       = br.legal & br.taken;
      end
      S_LINK: begin
        bus.ResultSrc = RES_PC;
        reg_write     = 1'b1;
      end
      S_JUMP: begin
        bus.ResultSrc  = RES_ALURESULT;
        bus.ALUsrcBsel = B_IMM;
        pc_write       = 1'b1;
        if (bus.opcode == OP_JAL) begin
          bus.ALUsrcAsel = A_OLDPC;
          bus.ImmSrc     = IMM_J;
        end else begin
          bus.ALUsrcAsel = A_REG;
        end
      end
      S_LUI: begin
        bus.ALUsrcAsel = A_ZERO;
        bus.ALUsrcBsel = B_IMM;
        bus.ImmSrc     = IMM_U;
        bus.ResultSrc  = RES_ALURESULT;
        reg_write      = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset parks the FSM in FETCH, whose decode asserts enables; gating with
  // rst keeps every write off for as long as reset is held.
  assign bus.PCwrite    = pc_write    & rst;
  assign bus.MemWrite   = mem_write   & rst;
  assign bus.OldPCwrite = oldpc_write & rst;
  assign bus.IRwrite    = ir_write    & rst;
  assign bus.RegWrite   = reg_write   & rst;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
// Self-checking bench: each instruction is expanded into the per-cycle control
// word sequence it must produce; a compare process checks the DUT every cycle.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

  localparam int TB_CNT_W = 4;

  typedef struct packed {
    logic       pcw;
    logic       adrsel;
    logic       memw;
    logic       oldpcw;
    logic       irw;
    logic       regw;
    logic [1:0] asel;
    logic [1:0] bsel;
    logic [1:0] rsrc;
    logic [2:0] imm;
    logic [2:0] alu;
  } ctl_t;

  logic                clk;
  logic                rst;
  logic                illegal;
  logic [TB_CNT_W-1:0] instret;

  multicycle_controller_if ifc ();

  multicycle_controller #(.CNT_W(TB_CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (ifc),
    .illegal (illegal),
    .instret (instret)
  );

  int    checks = 0;
  int    errors = 0;
  ctl_t  exp_ctl;
  logic  exp_ill;
  int    exp_cnt;
  bit    exp_valid = 0;
  string exp_name = "";
  int    m_cnt = 0;
  bit    m_ill = 0;
  bit    fix_zs = 0;
  logic  zero_fix = 0, sign_fix = 0;
  ctl_t  seen [8];
  int    memw_seen = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic ctl_t dut_ctl();
    ctl_t c;
    c.pcw    = ifc.PCwrite;
    c.adrsel = ifc.AdrSel;
    c.memw   = ifc.MemWrite;
    c.oldpcw = ifc.OldPCwrite;
    c.irw    = ifc.IRwrite;
    c.regw   = ifc.RegWrite;
    c.asel   = ifc.ALUsrcAsel;
    c.bsel   = ifc.ALUsrcBsel;
    c.rsrc   = ifc.ResultSrc;
    c.imm    = ifc.ImmSrc;
    c.alu    = ifc.ALUfunc;
    return c;
  endfunction

  // ---------------- reference model ----------------
  // {legal, ALUfunc}; illegal encodings leave ALUfunc at ADD.
  function automatic logic [3:0] model_alu(input logic [2:0] f3, input logic [6:0] f7, input bit rtype);
    if (rtype && !(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd0))) return 4'b0000;
    case (f3)
      3'd0:    return (rtype && f7 == 7'h20) ? 4'b1001 : 4'b1000;
      3'd7:    return 4'b1010;
      3'd6:    return 4'b1011;
      3'd4:    return 4'b1100;
      3'd2:    return 4'b1101;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic bit model_branch_ok(input logic [2:0] f3);
    return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5);
  endfunction

  function automatic bit model_taken(input logic [2:0] f3, input logic z, input logic s);
    case (f3)
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return s;
      3'd5:    return !s;
      default: return 1'b0;
    endcase
  endfunction

  // Cycles the instruction occupies, and whether it ends in ILLEGAL.
  function automatic int model_len(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [6:0] f7, output bit ill);
    logic [3:0] a;
    ill = 1'b0;
    case (op)
      7'b0000011: return 5;
      7'b0100011: return 4;
      7'b0110011: begin a = model_alu(f3, f7, 1'b1); ill = !a[3]; return a[3] ? 4 : 3; end
      7'b0010011: begin a = model_alu(f3, f7, 1'b0); ill = !a[3]; return a[3] ? 4 : 3; end
      7'b1100011: begin ill = !model_branch_ok(f3); return 3; end
      7'b1101111, 7'b1100111: return 4;
      7'b0110111: return 3;
      default: begin ill = 1'b1; return 2; end
    endcase
  endfunction

  // Control word required in cycle 'step' of an instruction.
  function automatic ctl_t model_step(input int step, input logic [6:0] op, input logic [2:0] f3,
                                      input logic [6:0] f7, input logic z, input logic s);
    ctl_t c;
    logic [3:0] a;
    c = '0;
    if (step == 0) begin
      c.irw = 1; c.oldpcw = 1; c.pcw = 1; c.bsel = 2'd2; c.rsrc = 2'd1;
      return c;
    end
    if (step == 1) begin
      c.asel = 2'd1; c.bsel = 2'd1; c.imm = 3'd2;
      return c;
    end
    case (op)
      7'b0000011: begin
        if (step == 2) begin c.asel = 2'd2; c.bsel = 2'd1; c.imm = 3'd0; end
        if (step == 3) c.adrsel = 1;
        if (step == 4) begin c.rsrc = 2'd2; c.regw = 1; end
      end
      7'b0100011: begin
        if (step == 2) begin c.asel = 2'd2; c.bsel = 2'd1; c.imm = 3'd1; end
        if (step == 3) begin c.adrsel = 1; c.memw = 1; end
      end
      7'b0110011, 7'b0010011: begin
        if (step == 2) begin
          a = model_alu(f3, f7, op == 7'b0110011);
          c.asel = 2'd2;
          c.bsel = (op == 7'b0110011) ? 2'd0 : 2'd1;
          c.alu  = a[2:0];
        end
        if (step == 3) c.regw = 1;
      end
      7'b1100011: begin
        c.asel = 2'd2; c.alu = 3'd1;
        c.pcw  = model_branch_ok(f3) && model_taken(f3, z, s);
      end
      7'b1101111, 7'b1100111: begin
        if (step == 2) begin c.rsrc = 2'd3; c.regw = 1; end
        if (step == 3) begin
          c.rsrc = 2'd1; c.pcw = 1; c.bsel = 2'd1;
          if (op == 7'b1101111) begin c.asel = 2'd1; c.imm = 3'd3; end
          else                  begin c.asel = 2'd2; c.imm = 3'd0; end
        end
      end
      7'b0110111: begin
        c.asel = 2'd3; c.bsel = 2'd1; c.imm = 3'd4; c.rsrc = 2'd1; c.regw = 1;
      end
      default: ;
    endcase
    return c;
  endfunction

  function automatic ctl_t reset_ctl();
    ctl_t c;
    c = '0;
    c.bsel = 2'd2;
    c.rsrc = 2'd1;
    return c;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (exp_valid) begin
      check({exp_name, " ctl"}, 32'(dut_ctl()), 32'(exp_ctl));
      check({exp_name, " illegal"}, 32'(illegal), 32'(exp_ill));
      check({exp_name, " instret"}, 32'(instret), exp_cnt);
    end
    if (ifc.MemWrite === 1'b1) memw_seen++;
  end

  // ---------------- driver ----------------
  task automatic slot();
    @(posedge clk);
    #1;
    ifc.zero = fix_zs ? zero_fix : 1'($urandom);
    ifc.sign = fix_zs ? sign_fix : 1'($urandom);
  endtask

  task automatic set_exp(input string name, input ctl_t c);
    exp_name  = name;
    exp_ctl   = c;
    exp_ill   = m_ill;
    exp_cnt   = m_cnt % (1 << TB_CNT_W);
    exp_valid = 1;
  endtask

  // Entered and left at the start of a FETCH cycle (or first ILLEGAL cycle).
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input int abort_step, output bit ill);
    int n;
    n = model_len(op, f3, f7, ill);
    for (int st = 0; st < n; st++) begin
      if (st > 0) slot();
      if (st == 0) begin
        ifc.opcode = op;
        ifc.func3  = f3;
        ifc.func7  = f7;
      end
      if (st == abort_step) begin
        rst = 1'b0;
        return;
      end
      set_exp($sformatf("op%07b f3=%0d f7=%02h step%0d", op, f3, f7, st),
              model_step(st, op, f3, f7, ifc.zero, ifc.sign));
      @(negedge clk);
      #1;
      seen[st] = dut_ctl();
    end
    slot();
    if (ill) m_ill = 1;
    else     m_cnt = m_cnt + 1;
  endtask

  task automatic run_word(input logic [31:0] w, input int abort_step, output bit ill);
    run_instr(w[6:0], w[14:12], w[31:25], abort_step, ill);
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    m_cnt = 0;
    m_ill = 0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) slot();
      set_exp("reset", reset_ctl());
    end
    slot();
    rst = 1'b1;
  endtask

  task automatic hold_illegal(input int n);
    for (int k = 0; k < n; k++) begin
      if (k > 0) slot();
      ifc.opcode = 7'($urandom);
      set_exp("illegal hold", '0);
    end
    slot();
  endtask

  initial begin
    bit   ill;
    int   mw0;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int   n, abort;

    rst = 1'b0;
    ifc.opcode = '0; ifc.func3 = '0; ifc.func7 = '0; ifc.zero = 1'b0; ifc.sign = 1'b0;
    slot();
    do_reset();
    check("instret after reset", 32'(instret), 32'd0);

    // add x3,x1,x2
    run_word(32'h002081B3, -1, ill);
    check("add EXEC_R ALUfunc", 32'(seen[2].alu), 32'd0);
    check("add ALUWB RegWrite", 32'(seen[3].regw), 32'd1);
    check("add ALUWB ResultSrc", 32'(seen[3].rsrc), 32'd0);
    check("add instret", 32'(instret), 32'd1);
    // lw x5,8(x1)
    run_word(32'h0080A283, -1, ill);
    check("lw MEMADR ImmSrc", 32'(seen[2].imm), 32'd0);
    check("lw MEMREAD AdrSel", 32'(seen[3].adrsel), 32'd1);
    check("lw MEMWB ResultSrc", 32'(seen[4].rsrc), 32'd2);
    check("lw MEMWB RegWrite", 32'(seen[4].regw), 32'd1);
    check("lw instret", 32'(instret), 32'd2);
    // sw
    mw0 = memw_seen;
    run_word(32'h0050A423, -1, ill);
    check("sw MemWrite cycles", 32'(memw_seen - mw0), 32'd1);
    check("sw instret", 32'(instret), 32'd3);
    // branches with forced flags
    fix_zs = 1; zero_fix = 1; sign_fix = 0;
    run_word(32'h00208463, -1, ill);
    check("beq z=1 PCwrite", 32'(seen[2].pcw), 32'd1);
    check("beq z=1 ResultSrc", 32'(seen[2].rsrc), 32'd0);
    zero_fix = 0;
    run_word(32'h00208463, -1, ill);
    check("beq z=0 PCwrite", 32'(seen[2].pcw), 32'd0);
    sign_fix = 1;
    run_word(32'h0020C463, -1, ill);
    check("blt s=1 PCwrite", 32'(seen[2].pcw), 32'd1);
    fix_zs = 0;
    // jal x1,16
    run_word(32'h010000EF, -1, ill);
    check("jal LINK ResultSrc", 32'(seen[2].rsrc), 32'd3);
    check("jal LINK RegWrite", 32'(seen[2].regw), 32'd1);
    check("jal JUMP ALUsrcAsel", 32'(seen[3].asel), 32'd1);
    check("jal JUMP ImmSrc", 32'(seen[3].imm), 32'd3);
    check("jal JUMP PCwrite", 32'(seen[3].pcw), 32'd1);
    // lui
    run_word(32'h123452B7, -1, ill);
    check("lui ALUsrcAsel", 32'(seen[2].asel), 32'd3);
    check("lui instret", 32'(instret), 32'd8);

    // reset asserted while a load sits in MEMREAD
    run_word(32'h0080A283, 3, ill);
    do_reset();
    check("instret after mid-MEMREAD reset", 32'(instret), 32'd0);

    // undefined opcode, after one retired add
    run_word(32'h002081B3, -1, ill);
    run_word(32'h0000007F, -1, ill);
    hold_illegal(20);
    check("illegal opcode flag held", 32'(illegal), 32'd1);
    check("illegal opcode instret frozen", 32'(instret), 32'd1);
    do_reset();

    // R-type with func7 = 0x01
    run_word(32'h022081B3, -1, ill);
    check("bad func7 ends illegal", 32'(ill), 32'd1);
    hold_illegal(20);
    check("bad func7 flag held", 32'(illegal), 32'd1);
    do_reset();

    // randomized instruction stream
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0:       op = 7'b0000011;
        1:       op = 7'b0100011;
        2, 3:    op = 7'b0110011;
        4, 5:    op = 7'b0010011;
        6:       op = 7'b1100011;
        7:       op = ($urandom_range(0, 1) != 0) ? 7'b1101111 : 7'b1100111;
        8:       op = 7'b0110111;
        default: op = 7'($urandom);
      endcase
      f3 = 3'($urandom);
      case ($urandom_range(0, 4))
        0, 1, 2: f7 = 7'h00;
        3:       f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      n = model_len(op, f3, f7, ill);
      abort = ($urandom_range(0, 99) < 3) ? int'($urandom_range(0, n - 1)) : -1;
      run_instr(op, f3, f7, abort, ill);
      if (abort >= 0) begin
        do_reset();
      end else if (ill) begin
        hold_illegal(int'($urandom_range(1, 4)));
        do_reset();
      end
    end

    exp_valid = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
